// File: rtl/jump_loader.sv
// ============================================================================
//  Module      : jump_loader
//  Description : Branch/jump unit that evaluates a jump condition against ALU
//                flags and drives the PC load interface for HOLD_CYCLES clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_loader #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       cond,
  input  logic             rel,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] pc_now,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_n,
  output logic             load_mode,
  output logic [WIDTH-1:0] load_value,
  output logic [7:0]       taken_count,
  output logic             busy
);

  localparam int                c_CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [2:0]         r_cond;
  logic               r_rel;
  logic [WIDTH-1:0]   r_target;
  logic [WIDTH-1:0]   r_pc;
  logic               r_z;
  logic               r_c;
  logic               r_n;

  logic               r_load_mode;
  logic [WIDTH-1:0]   r_load_value;
  logic [7:0]         r_count;
  logic [c_CNT_W-1:0] r_hold;

  logic               w_load_mode_next;
  logic [WIDTH-1:0]   w_load_value_next;
  logic [7:0]         w_count_next;
  logic [c_CNT_W-1:0] w_hold_next;
  logic               w_capture;
  logic               w_taken;
  logic [WIDTH-1:0]   w_dest;

  // Condition is evaluated only from the snapshot taken at the accept edge.
  always_comb begin
    w_taken = 1'b0;
    case (r_cond)
      3'b000:  w_taken = 1'b0;
      3'b001:  w_taken = 1'b1;
      3'b010:  w_taken = r_z;
      3'b011:  w_taken = ~r_z;
      3'b100:  w_taken = r_c;
      3'b101:  w_taken = ~r_c;
      3'b110:  w_taken = r_n;
      3'b111:  w_taken = ~r_n;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_dest = r_rel ? (r_pc + r_target) : r_target;

  always_comb begin
    w_state_next      = r_state;
    w_load_mode_next  = r_load_mode;
    w_load_value_next = r_load_value;
    w_count_next      = r_count;
    w_hold_next       = r_hold;
    w_capture         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_capture    = 1'b1;
          w_state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (w_taken) begin
          w_load_mode_next  = 1'b1;
          w_load_value_next = w_dest;
          w_count_next      = r_count + 8'd1;
          w_hold_next       = c_HOLD_LAST;
          w_state_next      = S_LOAD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (r_hold == '0) begin
          w_load_mode_next = 1'b0;
          w_state_next     = S_IDLE;
        end else begin
          w_hold_next = r_hold - c_CNT_W'(1);
        end
      end
      default: begin
        w_load_mode_next = 1'b0;
        w_state_next     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_load_mode  <= 1'b0;
      r_load_value <= '0;
      r_count      <= 8'd0;
      r_hold       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_load_mode  <= w_load_mode_next;
      r_load_value <= w_load_value_next;
      r_count      <= w_count_next;
      r_hold       <= w_hold_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cond   <= 3'b000;
      r_rel    <= 1'b0;
      r_target <= '0;
      r_pc     <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
    end else if (w_capture) begin
      r_cond   <= cond;
      r_rel    <= rel;
      r_target <= target;
      r_pc     <= pc_now;
      r_z      <= flag_z;
      r_c      <= flag_c;
      r_n      <= flag_n;
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = ~instr_ready;
  assign load_mode   = r_load_mode;
  assign load_value  = r_load_value;
  assign taken_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_jump_loader.sv
// ============================================================================
//  Module      : tb_jump_loader
//  Description : Self-checking bench for jump_loader against a transaction-level
//                model of condition, destination and load-window timing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jump_loader;

  localparam int c_W = 8;
  localparam int c_H = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           instr_valid = 1'b0;
  logic           instr_ready;
  logic [2:0]     cond = 3'b000;
  logic           rel = 1'b0;
  logic [c_W-1:0] target = '0;
  logic [c_W-1:0] pc_now = '0;
  logic           flag_z = 1'b0;
  logic           flag_c = 1'b0;
  logic           flag_n = 1'b0;
  logic           load_mode;
  logic [c_W-1:0] load_value;
  logic [7:0]     taken_count;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lv   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  jump_loader #(.WIDTH(c_W), .HOLD_CYCLES(c_H)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .cond        (cond),
    .rel         (rel),
    .target      (target),
    .pc_now      (pc_now),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_n      (flag_n),
    .load_mode   (load_mode),
    .load_value  (load_value),
    .taken_count (taken_count),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_taken(input int c, input bit z, input bit cy, input bit n);
    case (c)
      0: return 1'b0;
      1: return 1'b1;
      2: return z;
      3: return !z;
      4: return cy;
      5: return !cy;
      6: return n;
      default: return !n;
    endcase
  endfunction

  // One instruction from accept to the cycle where the unit is ready again.
  // Starts and ends at a falling edge with the unit idle.
  task automatic do_jump(input int c, input bit r, input int t, input int p,
                         input bit z, input bit cy, input bit n);
    bit tk;
    int dest, prev_lv, prev_cnt, last;
    tk       = model_taken(c, z, cy, n);
    dest     = r ? ((p + t) % 256) : t;
    prev_lv  = exp_lv;
    prev_cnt = exp_cnt;
    if (tk) begin
      exp_lv  = dest;
      exp_cnt = (exp_cnt + 1) % 256;
    end
    last = tk ? c_H + 1 : 1;

    instr_valid = 1'b1;
    cond   = 3'(c);
    rel    = r;
    target = 8'(t);
    pc_now = 8'(p);
    flag_z = z;
    flag_c = cy;
    flag_n = n;
    check_eq("ready_before_accept", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    // Keep valid asserted with garbage to prove no capture while busy.
    cond   = 3'($urandom);
    rel    = 1'($urandom);
    target = 8'($urandom);
    pc_now = 8'($urandom);
    flag_z = ~z;
    flag_c = ~cy;
    flag_n = ~n;

    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      check_eq("load_mode",   load_mode,   (tk && j >= 1 && j <= c_H) ? 1 : 0);
      check_eq("instr_ready", instr_ready, (j == last) ? 1 : 0);
      check_eq("busy",        busy,        (j == last) ? 0 : 1);
      check_eq("load_value",  load_value,  (j == 0) ? prev_lv : exp_lv);
      check_eq("taken_count", taken_count, (j == 0) ? prev_cnt : exp_cnt);
      if (j == last) instr_valid = 1'b0;
    end
  endtask

  initial begin
    // Asynchronous reset mid-cycle, no clock edge in between.
    #3 rst = 1'b1;
    #1;
    check_eq("rst_load_mode",   load_mode,   0);
    check_eq("rst_load_value",  load_value,  0);
    check_eq("rst_taken_count", taken_count, 0);
    check_eq("rst_instr_ready", instr_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_lv  = 0;
    exp_cnt = 0;

    do_jump(1, 0, 'h3C, 'h55, 0, 0, 0);
    check_eq("abs_value", load_value, 'h3C);
    check_eq("abs_count", taken_count, 1);

    do_jump(2, 0, 'hA0, 'h20, 0, 1, 1);
    check_eq("nt_value", load_value, 'h3C);

    do_jump(1, 1, 'h03, 'hFE, 0, 0, 0);
    check_eq("rel_wrap", load_value, 'h01);
    do_jump(1, 1, 'hFC, 'h10, 0, 0, 0);
    check_eq("rel_neg", load_value, 'h0C);
    do_jump(0, 0, 'h77, 'h00, 1, 1, 1);

    for (int i = 0; i < 60; i++) begin
      do_jump(int'($urandom_range(7)), 1'($urandom), int'($urandom_range(255)),
              int'($urandom_range(255)), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the second LOAD cycle: load window dropped, not resumed.
    instr_valid = 1'b1;
    cond   = 3'b001;
    rel    = 1'b0;
    target = 8'h9A;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("midload_high", load_mode, 1);
    rst = 1'b1;
    #1;
    check_eq("midload_drop",  load_mode,   0);
    check_eq("midload_value", load_value,  0);
    check_eq("midload_count", taken_count, 0);
    check_eq("midload_ready", instr_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_lv  = 0;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_resume_mode",  load_mode,   0);
      check_eq("no_resume_ready", instr_ready, 1);
    end

    for (int i = 0; i < 256; i++) begin
      do_jump(1, 1'($urandom), int'($urandom_range(255)), int'($urandom_range(255)),
              1'($urandom), 1'($urandom), 1'($urandom));
    end
    check_eq("count_wrap", taken_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
